hdmi_video_tx: RTL

//  Downstream of the upscaler, in the clk_h domain. Takes the hx/hy frame counters and rgb_h pixels.

---
 rtl/hdmi_pkg.sv | 33 +++
 rtl/hdmi_video_tx_tmds_channel_encoder.sv | 72 +++++++
 rtl/hdmi_video_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and fixed TMDS symbols for the HDMI video transmitter.
package hdmi_pkg;

    typedef logic [9:0] tmds_sym_t;

    typedef enum logic [1:0] {
        CTRL     = 2'd0,
        PREAMBLE = 2'd1,
        GUARD    = 2'd2,
        VIDEO    = 2'd3
    } period_t;

    // Sync flags here mean "asserted", independent of the output polarity.
    typedef struct packed {
        period_t period;
        logic    hs;
        logic    vs;
    } timing_t;

    localparam timing_t TIM_IDLE = timing_t'{CTRL, 1'b0, 1'b0};

    localparam tmds_sym_t CTL_CODE [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam tmds_sym_t GUARD_CH0 = 10'b1011001100;
    localparam tmds_sym_t GUARD_CH1 = 10'b0100110011;
    localparam tmds_sym_t GUARD_CH2 = 10'b1011001100;

endpackage

// File: rtl/hdmi_video_tx_tmds_channel_encoder.sv
// One TMDS lane: DVI 8b/10b video coding, control and guard symbols, registered output.
module tmds_channel_encoder
    import hdmi_pkg::*;
#(
    parameter tmds_sym_t RST_SYM = 10'b1101010100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] period_i,
    input  logic [7:0] data_i,
    input  logic [1:0] c_i,
    input  logic [9:0] guard_i,
    output logic [9:0] sym_o
);

    logic [8:0]        qm;
    logic [3:0]        n1_data;
    logic [3:0]        n1_qm;
    logic              use_xnor;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;
    tmds_sym_t         sym_q;
    tmds_sym_t         sym_d;

    always_comb begin
        n1_data = '0;
        for (int i = 0; i < 8; i++) n1_data = n1_data + {3'b000, data_i[i]};
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_i[0]);

        qm    = '0;
        qm[0] = data_i[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ data_i[i]) : (qm[i-1] ^ data_i[i]);
        qm[8] = ~use_xnor;

        n1_qm = '0;
        for (int i = 0; i < 8; i++) n1_qm = n1_qm + {3'b000, qm[i]};
        // ones minus zeros of the 8 coded bits, kept in mod-32 arithmetic
        diff = $signed({n1_qm, 1'b0}) - 5'sd8;

        if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            sym_d = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            cnt_d = qm[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                     ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
            sym_d = {1'b1, qm[8], ~qm[7:0]};
            cnt_d = cnt_q + (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            sym_d = {1'b0, qm[8], qm[7:0]};
            cnt_d = cnt_q - (qm[8] ? 5'sd0 : 5'sd2) + diff;
        end

        if (period_i != VIDEO) begin
            cnt_d = '0;
            sym_d = (period_i == GUARD) ? guard_i : CTL_CODE[c_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sym_q <= RST_SYM;
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign sym_o = sym_q;

endmodule

// File: rtl/hdmi_video_tx.sv
// HDMI/DVI video transmitter: timing decode from hx/hy, rgb alignment, three TMDS lanes.
module hdmi_video_tx
    import hdmi_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 720,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAME_WIDTH   = 858,
    parameter int FRAME_HEIGHT  = 525,
    parameter int HSYNC_START   = 736,
    parameter int HSYNC_LEN     = 62,
    parameter int VSYNC_START   = 489,
    parameter int VSYNC_LEN     = 6,
    parameter int SYNC_ACTIVE   = 0,
    parameter int RGB_DELAY     = 1,
    parameter int DVI_MODE      = 0
) (
    input  logic        clk_h,
    input  logic        rst_h,
    input  logic [9:0]  hx,
    input  logic [9:0]  hy,
    input  logic [23:0] rgb_h,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o
);

    localparam logic       SYNC_ON    = (SYNC_ACTIVE != 0);
    localparam logic       DVI        = (DVI_MODE != 0);
    localparam logic [9:0] SW         = 10'(SCREEN_WIDTH);
    localparam logic [9:0] SH         = 10'(SCREEN_HEIGHT);
    localparam logic [9:0] SH_M1      = 10'(SCREEN_HEIGHT - 1);
    localparam logic [9:0] FH_LAST    = 10'(FRAME_HEIGHT - 1);
    localparam logic [9:0] FW_LAST    = 10'(FRAME_WIDTH - 1);
    localparam logic [9:0] FW_GUARD   = 10'(FRAME_WIDTH - 2);
    localparam logic [9:0] FW_PRE_END = 10'(FRAME_WIDTH - 3);
    localparam logic [9:0] FW_PRE     = 10'(FRAME_WIDTH - 10);
    localparam logic [9:0] HS_FIRST   = 10'(HSYNC_START);
    localparam logic [9:0] HS_END     = 10'(HSYNC_START + HSYNC_LEN);
    localparam logic [9:0] VS_FIRST   = 10'(VSYNC_START);
    localparam logic [9:0] VS_END     = 10'(VSYNC_START + VSYNC_LEN);
    localparam tmds_sym_t  CH0_RST    = CTL_CODE[{~SYNC_ON, ~SYNC_ON}];

    timing_t     tim_now;
    timing_t     tim_dly;
    timing_t     e1_q;
    logic [23:0] rgb_e1_q;
    logic        de_now;
    logic        next_act;
    logic        hs_lvl;
    logic        vs_lvl;
    logic [1:0]  c_ch1;

    always_comb begin
        tim_now    = TIM_IDLE;
        de_now     = (hx < SW) && (hy < SH);
        // the line after this one carries video, so it needs preamble and guard band
        next_act   = (hy == FH_LAST) || (hy < SH_M1);
        tim_now.hs = (hx >= HS_FIRST) && (hx < HS_END);
        tim_now.vs = (hy >= VS_FIRST) && (hy < VS_END);
        if (de_now)
            tim_now.period = VIDEO;
        else if (!DVI && next_act && (hx >= FW_GUARD) && (hx <= FW_LAST))
            tim_now.period = GUARD;
        else if (!DVI && next_act && (hx >= FW_PRE) && (hx <= FW_PRE_END))
            tim_now.period = PREAMBLE;
    end

    generate
        if (RGB_DELAY == 0) begin : g_nodly
            assign tim_dly = tim_now;
        end else begin : g_dly
            timing_t dly_q [RGB_DELAY];
            always_ff @(posedge clk_h) begin
                if (rst_h) begin
                    for (int i = 0; i < RGB_DELAY; i++) dly_q[i] <= TIM_IDLE;
                end else begin
                    dly_q[0] <= tim_now;
                    for (int i = 1; i < RGB_DELAY; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign tim_dly = dly_q[RGB_DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            e1_q     <= TIM_IDLE;
            rgb_e1_q <= '0;
        end else begin
            e1_q     <= tim_dly;
            rgb_e1_q <= rgb_h;
        end
    end

    assign hs_lvl = e1_q.hs ? SYNC_ON : ~SYNC_ON;
    assign vs_lvl = e1_q.vs ? SYNC_ON : ~SYNC_ON;
    assign c_ch1  = (e1_q.period == PREAMBLE) ? 2'b01 : 2'b00;

    tmds_channel_encoder #(.RST_SYM(CH0_RST)) u_enc0 (
        .clk_i(clk_h), .rst_i(rst_h), .period_i(e1_q.period), .data_i(rgb_e1_q[7:0]),
        .c_i({vs_lvl, hs_lvl}), .guard_i(GUARD_CH0), .sym_o(tmds_ch0)
    );

    tmds_channel_encoder #(.RST_SYM(CTL_CODE[0])) u_enc1 (
        .clk_i(clk_h), .rst_i(rst_h), .period_i(e1_q.period), .data_i(rgb_e1_q[15:8]),
        .c_i(c_ch1), .guard_i(GUARD_CH1), .sym_o(tmds_ch1)
    );

    tmds_channel_encoder #(.RST_SYM(CTL_CODE[0])) u_enc2 (
        .clk_i(clk_h), .rst_i(rst_h), .period_i(e1_q.period), .data_i(rgb_e1_q[23:16]),
        .c_i(2'b00), .guard_i(GUARD_CH2), .sym_o(tmds_ch2)
    );

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            de_o    <= 1'b0;
            hsync_o <= ~SYNC_ON;
            vsync_o <= ~SYNC_ON;
        end else begin
            de_o    <= (e1_q.period == VIDEO);
            hsync_o <= hs_lvl;
            vsync_o <= vs_lvl;
        end
    end

endmodule
